// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU responder slice.
//   ALU_W     - datapath width (fixed at 32)
//   CNT_W     - width of the divider's iteration counter
//   opcode_e  - 3-bit operation selector carried on the select port
//   state_e   - responder control states
//   alu_res_t - result of a single-cycle operation (carry-out + value)
// Optional feature macro: ALU_MOD_EN (enables the iterative modulo unit).
package alu_pkg;

  localparam int ALU_W = 32;
  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_XOR = 3'b011,
    OP_SUB = 3'b100,
    OP_SLT = 3'b101,
    OP_NOR = 3'b110,
    OP_MOD = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic             c_o;
    logic [ALU_W-1:0] out;
  } alu_res_t;

endpackage

// File: rtl/alu_mod_unit.sv
// alu_mod_unit: iterative restoring divider producing an unsigned remainder.
// One quotient bit is resolved per clock, MSB first, over 32 cycles.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   start       - load dividend/divisor and begin (ignored while busy)
//   dividend    - numerator, captured on start
//   divisor     - denominator, captured on start (caller excludes zero)
//   done        - high during the final iteration cycle
//   remainder   - final remainder, valid while done is high
// Only instantiated when ALU_MOD_EN is defined.
module alu_mod_unit
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ALU_W-1:0] dividend,
  input  logic [ALU_W-1:0] divisor,
  output logic             done,
  output logic [ALU_W-1:0] remainder
);

  logic [ALU_W-1:0] rem_reg;
  logic [ALU_W-1:0] quo_reg;   // starts as the dividend, fills with quotient bits
  logic [ALU_W-1:0] dsr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;

  logic [ALU_W:0]   shifted;
  logic [ALU_W:0]   trial;
  logic             fits;
  logic [ALU_W-1:0] rem_next;
  logic [ALU_W-1:0] quo_next;

  // One restoring step: bring down the next dividend bit, try to subtract.
  // The shifted partial remainder can need 33 bits, so the trial subtract is
  // done at 33 bits and its MSB is the borrow.
  always_comb begin
    shifted  = {rem_reg, quo_reg[ALU_W-1]};
    trial    = shifted - {1'b0, dsr_reg};
    fits     = ~trial[ALU_W];
    rem_next = fits ? trial[ALU_W-1:0] : shifted[ALU_W-1:0];
    quo_next = {quo_reg[ALU_W-2:0], fits};
  end

  // The last step's result is presented combinationally so the caller can
  // register it on the same edge that finishes the iteration.
  assign done      = busy_reg && (cnt_reg == '0);
  assign remainder = rem_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      dsr_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start && !busy_reg) begin
      rem_reg  <= '0;
      quo_reg  <= dividend;
      dsr_reg  <= divisor;
      cnt_reg  <= CNT_W'(ALU_W - 1);
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      rem_reg <= rem_next;
      quo_reg <= quo_next;
      cnt_reg <= cnt_reg - 1'b1;
      if (cnt_reg == '0) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_responder.sv
// alu_responder: handshaked 32-bit ALU responder.
// Accepts {i1, i2, select, c_in} on a valid/ready request channel, computes
// the result and returns {out, c_o, div_zero, illegal} on a valid/ready
// response channel. One operation is in flight at a time.
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   req_valid / req_ready - request handshake (ready only when idle)
//   i1, i2, select, c_in  - operands, opcode, carry-in (ADD only)
//   rsp_valid / rsp_ready - response handshake
//   out, c_o              - result value and carry-out
//   div_zero              - MOD attempted with i2 == 0
//   illegal               - opcode not supported by this build
// Build option: ALU_MOD_EN enables the iterative MOD unit; without it,
// opcode 111 answers in one cycle with illegal = 1.
module alu_responder
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ALU_W-1:0] i1,
  input  logic [ALU_W-1:0] i2,
  input  logic [2:0]       select,
  input  logic             c_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ALU_W-1:0] out,
  output logic             c_o,
  output logic             div_zero,
  output logic             illegal
);

  // All single-cycle operations. MOD is handled by the FSM, so it only
  // appears here as a don't-care default.
  function automatic alu_res_t alu_single(
    input opcode_e          op,
    input logic [ALU_W-1:0] a,
    input logic [ALU_W-1:0] b,
    input logic             cin
  );
    alu_res_t       res;
    logic [ALU_W:0] sum;
    res = '0;
    sum = '0;
    case (op)
      OP_AND: res.out = a & b;
      OP_OR:  res.out = a | b;
      OP_XOR: res.out = a ^ b;
      OP_NOR: res.out = ~(a | b);
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b} + {{ALU_W{1'b0}}, cin};
        res = {sum[ALU_W], sum[ALU_W-1:0]};
      end
      OP_SUB: begin
        // Carry-out of a + ~b + 1 is the inverted borrow.
        sum = {1'b0, a} + {1'b0, ~b} + {{ALU_W{1'b0}}, 1'b1};
        res = {sum[ALU_W], sum[ALU_W-1:0]};
      end
      OP_SLT: res.out = {{(ALU_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: res = '0;
    endcase
    return res;
  endfunction

  state_e           state_reg;
  logic             req_ready_reg;
  logic             rsp_valid_reg;
  logic [ALU_W-1:0] out_reg;
  logic             c_o_reg;
  logic             div_zero_reg;
  logic             illegal_reg;

  alu_res_t         single_res;
  logic             accept;
  logic             is_mod;

  assign accept = (state_reg == IDLE) && req_valid;
  assign is_mod = (select == OP_MOD);

  always_comb begin
    single_res = alu_single(opcode_e'(select), i1, i2, c_in);
  end

`ifdef ALU_MOD_EN
  logic             mod_start;
  logic             mod_done;
  logic [ALU_W-1:0] mod_rem;

  // Division by zero never starts the divider; it is answered directly.
  assign mod_start = accept && is_mod && (i2 != '0);

  alu_mod_unit u_mod (
    .clk       (clk),
    .reset     (reset),
    .start     (mod_start),
    .dividend  (i1),
    .divisor   (i2),
    .done      (mod_done),
    .remainder (mod_rem)
  );
`endif

  // Control FSM. Handshake outputs are flops updated alongside the state so
  // neither req_valid nor rsp_ready reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      out_reg       <= '0;
      c_o_reg       <= 1'b0;
      div_zero_reg  <= 1'b0;
      illegal_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            div_zero_reg <= 1'b0;
            illegal_reg  <= 1'b0;
            if (is_mod) begin
`ifdef ALU_MOD_EN
              c_o_reg <= 1'b0;
              if (i2 == '0) begin
                out_reg       <= i1;
                div_zero_reg  <= 1'b1;
                state_reg     <= RESP;
                req_ready_reg <= 1'b0;
                rsp_valid_reg <= 1'b1;
              end else begin
                state_reg     <= CALC;
                req_ready_reg <= 1'b0;
              end
`else
              out_reg       <= '0;
              c_o_reg       <= 1'b0;
              illegal_reg   <= 1'b1;
              state_reg     <= RESP;
              req_ready_reg <= 1'b0;
              rsp_valid_reg <= 1'b1;
`endif
            end else begin
              out_reg       <= single_res.out;
              c_o_reg       <= single_res.c_o;
              state_reg     <= RESP;
              req_ready_reg <= 1'b0;
              rsp_valid_reg <= 1'b1;
            end
          end
        end

        CALC: begin
`ifdef ALU_MOD_EN
          if (mod_done) begin
            out_reg       <= mod_rem;
            state_reg     <= RESP;
            rsp_valid_reg <= 1'b1;
          end
`else
          // Unreachable without the divider; recover to a sane state.
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
          rsp_valid_reg <= 1'b0;
`endif
        end

        RESP: begin
          if (rsp_ready) begin
            state_reg     <= IDLE;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
          end
        end

        default: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
          rsp_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign out       = out_reg;
  assign c_o       = c_o_reg;
  assign div_zero  = div_zero_reg;
  assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_responder.sv
// tb_alu_responder: self-checking bench for alu_responder.
// Directed cases plus randomized operations checked against an arithmetic
// reference model. Honours ALU_MOD_EN the same way as the design.
module tb_alu_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] i1;
  logic [31:0] i2;
  logic [2:0]  select;
  logic        c_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] out;
  logic        c_o;
  logic        div_zero;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] out;
    logic        c_o;
    logic        dz;
    logic        il;
  } rsp_t;

  alu_responder dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .i1        (i1),
    .i2        (i2),
    .select    (select),
    .c_in      (c_in),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .out       (out),
    .c_o       (c_o),
    .div_zero  (div_zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, required finish before 600000");
    $fatal(1);
  end

  // Reference model from the operation rules, plain arithmetic.
  function automatic rsp_t model(input int op, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin);
    rsp_t   r;
    longint s;
    r = '0;
    case (op)
      0: r.out = a & b;
      1: r.out = a | b;
      2: begin
        s = longint'(a) + longint'(b) + longint'(cin);
        r.out = s[31:0];
        r.c_o = (s >= 64'h1_0000_0000);
      end
      3: r.out = a ^ b;
      4: begin
        r.out = a - b;
        r.c_o = (a >= b);
      end
      5: r.out = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      6: r.out = ~(a | b);
      default: begin
`ifdef ALU_MOD_EN
        if (b == 0) begin
          r.out = a;
          r.dz  = 1'b1;
        end else begin
          r.out = a % b;
        end
`else
        r.il = 1'b1;
`endif
      end
    endcase
    return r;
  endfunction

  function automatic int model_lat(input int op, input logic [31:0] b);
`ifdef ALU_MOD_EN
    return (op == 7 && b != 0) ? 33 : 1;
`else
    return 1;
`endif
  endfunction

  // Issues one request, waits for the response, consumes it. No checking.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, output rsp_t r, output int lat);
    int w;
    w = 0;
    while (!req_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_ready_wait: req_ready=%0b required 1 within 100 cycles", req_ready);
    end
    select = op; i1 = a; i2 = b; c_in = cin; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    i1 = $urandom; i2 = $urandom; select = 3'($urandom); c_in = 1'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = '{out: out, c_o: c_o, dz: div_zero, il: illegal};
    $display("txn op=%0d a=%h b=%h cin=%0b -> out=%h c_o=%0b dz=%0b il=%0b lat=%0d",
             op, a, b, cin, r.out, r.c_o, r.dz, r.il, lat);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_cmp++;
    if ({req_ready, rsp_valid, out, c_o, div_zero, illegal} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: req_ready=%b rsp_valid=%b out=%h c_o=%b dz=%b il=%b required 1 0 0 0 0 0",
               req_ready, rsp_valid, out, c_o, div_zero, illegal);
    end
  endtask

  task automatic test_single_ops();
    logic [2:0]  ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3};
    logic [31:0] exp [5] = '{32'h00001000, 32'h10101001, 32'h10102001, 32'h0FF00001, 32'h10100001};
    logic        eco [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rsp_t r;
    int   lat;
    for (int k = 0; k < 5; k++) begin
      run_op(ops[k], 32'h10001001, 32'h00101000, 1'b0, r, lat);
      n_cmp++;
      if (r !== {exp[k], eco[k], 1'b0, 1'b0} || lat != 1) begin
        n_err++;
        $display("FAIL single_op%0d: out=%h c_o=%b lat=%0d required out=%h c_o=%b lat=1",
                 ops[k], r.out, r.c_o, lat, exp[k], eco[k]);
      end
    end
  endtask

  task automatic test_carry_sign();
    rsp_t r;
    int   lat;
    run_op(3'd2, 32'hFFFFFFFF, 32'h0, 1'b1, r, lat);
    n_cmp++;
    if (r !== {32'h0, 1'b1, 1'b0, 1'b0} || lat != 1) begin
      n_err++;
      $display("FAIL add_carry: out=%h c_o=%b lat=%0d required out=0 c_o=1 lat=1", r.out, r.c_o, lat);
    end
    run_op(3'd5, 32'hFFFFFFFF, 32'h1, 1'b0, r, lat);
    n_cmp++;
    if (r !== {32'h1, 1'b0, 1'b0, 1'b0} || lat != 1) begin
      n_err++;
      $display("FAIL slt_signed: out=%h c_o=%b lat=%0d required out=1 c_o=0 lat=1", r.out, r.c_o, lat);
    end
  endtask

  task automatic test_mod();
    rsp_t        r;
    int          lat;
    logic [31:0] a;
`ifdef ALU_MOD_EN
    run_op(3'd7, 32'd100, 32'd7, 1'b0, r, lat);
    n_cmp++;
    if (r !== {32'd2, 1'b0, 1'b0, 1'b0} || lat != 33) begin
      n_err++;
      $display("FAIL mod_100_7: out=%0d dz=%b lat=%0d required out=2 dz=0 lat=33", r.out, r.dz, lat);
    end
    a = $urandom;
    run_op(3'd7, a, 32'd0, 1'b0, r, lat);
    n_cmp++;
    if (r !== {a, 1'b0, 1'b1, 1'b0} || lat != 1) begin
      n_err++;
      $display("FAIL mod_zero: out=%h c_o=%b dz=%b lat=%0d required out=%h c_o=0 dz=1 lat=1",
               r.out, r.c_o, r.dz, lat, a);
    end
`else
    a = $urandom;
    run_op(3'd7, a, 32'd7, 1'b1, r, lat);
    n_cmp++;
    if (r !== {32'h0, 1'b0, 1'b0, 1'b1} || lat != 1) begin
      n_err++;
      $display("FAIL mod_illegal: out=%h c_o=%b il=%b lat=%0d required out=0 c_o=0 il=1 lat=1",
               r.out, r.c_o, r.il, lat);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op [9];
    logic [31:0] a  [9];
    logic [31:0] b  [9];
    logic        c  [9];
    rsp_t        e;
    for (int k = 0; k < 9; k++) begin
      op[k] = 3'($urandom_range(0, 6));
      a[k] = $urandom; b[k] = $urandom; c[k] = 1'($urandom);
    end
    rsp_ready = 1'b1;
    select = op[0]; i1 = a[0]; i2 = b[0]; c_in = c[0]; req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      e = model(int'(op[k]), a[k], b[k], c[k]);
      $display("txn b2b op=%0d a=%h b=%h -> out=%h c_o=%0b", op[k], a[k], b[k], out, c_o);
      n_cmp++;
      if ({rsp_valid, req_ready, out, c_o, div_zero, illegal} !== {1'b1, 1'b0, e}) begin
        n_err++;
        $display("FAIL b2b_rsp%0d: valid=%b ready=%b out=%h c_o=%b required valid=1 ready=0 out=%h c_o=%b",
                 k, rsp_valid, req_ready, out, c_o, e.out, e.c_o);
      end
      // Next operands presented while busy; must not be taken until idle.
      select = op[k+1]; i1 = a[k+1]; i2 = b[k+1]; c_in = c[k+1];
      @(posedge clk); #1;
      n_cmp++;
      if ({req_ready, rsp_valid} !== 2'b10) begin
        n_err++;
        $display("FAIL b2b_idle%0d: req_ready=%b rsp_valid=%b required 1 0", k, req_ready, rsp_valid);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    rsp_t        e;
    rsp_t        r;
    int          lat;
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom; b = $urandom;
    e = model(2, a, b, 1'b1);
    select = 3'd2; i1 = a; i2 = b; c_in = 1'b1; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    select = 3'd3; i1 = ~a; i2 = 32'h5A5A5A5A;   // ignored request
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if ({rsp_valid, req_ready, out, c_o} !== {1'b1, 1'b0, e.out, e.c_o}) begin
        n_err++;
        $display("FAIL backpressure_hold%0d: valid=%b ready=%b out=%h c_o=%b required 1 0 %h %b",
                 k, rsp_valid, req_ready, out, c_o, e.out, e.c_o);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_cmp++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL backpressure_release: req_ready=%b rsp_valid=%b required 1 0", req_ready, rsp_valid);
    end
    a = $urandom; b = $urandom;
    run_op(3'd6, a, b, 1'b0, r, lat);
    e = model(6, a, b, 1'b0);
    n_cmp++;
    if (r !== e || lat != 1) begin
      n_err++;
      $display("FAIL backpressure_next: out=%h lat=%0d required out=%h lat=1", r.out, lat, e.out);
    end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    // Reset while a response is being held.
    select = 3'd1; i1 = $urandom; i2 = $urandom; c_in = 1'b0; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if ({req_ready, rsp_valid, out} !== {1'b1, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_mid_resp: req_ready=%b rsp_valid=%b out=%h required 1 0 0", req_ready, rsp_valid, out);
    end
`ifdef ALU_MOD_EN
    // Reset at cycle 15 of a MOD.
    select = 3'd7; i1 = $urandom; i2 = 32'd3 + 32'($urandom_range(0, 1000)); req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_mid_calc: req_ready=%b rsp_valid=%b required 1 0", req_ready, rsp_valid);
    end
`endif
    seen = 0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL reset_no_response: rsp_valid cycles=%0d required 0", seen);
    end
  endtask

  task automatic test_random();
    rsp_t        r;
    rsp_t        e;
    int          lat;
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    for (int k = 0; k < 30; k++) begin
      op = $urandom_range(0, 7);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      c = 1'($urandom);
      run_op(3'(op), a, b, c, r, lat);
      e = model(op, a, b, c);
      n_cmp++;
      if (r !== e || lat != model_lat(op, b)) begin
        n_err++;
        $display("FAIL random%0d op=%0d a=%h b=%h: out=%h c_o=%b dz=%b il=%b lat=%0d required %h %b %b %b %0d",
                 k, op, a, b, r.out, r.c_o, r.dz, r.il, lat, e.out, e.c_o, e.dz, e.il, model_lat(op, b));
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    i1 = '0; i2 = '0; select = '0; c_in = 1'b0;
    test_reset();
    test_single_ops();
    test_carry_sign();
    test_mod();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
